// File: rtl/id_stage.sv
// id_stage: decode, register read, branch resolution and hazard stalls for the 16-bit pipeline.
// Define ID_PERF_CNT_EN to add the stall_cnt/branch_cnt performance counters.
module id_stage #(
    parameter int RESET_VECTOR = 8,
    parameter int FETCH_SHADOW = 2,
    parameter int NREGS        = 8
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [15:0] id_instr,
    input  logic [15:0] id_instr_addr,
    input  logic        wb_wr_en,
    input  logic [2:0]  wb_rd,
    input  logic [15:0] wb_data,
    input  logic        ex_dst_vld,
    input  logic [2:0]  ex_dst,
    input  logic        mem_dst_vld,
    input  logic [2:0]  mem_dst,
    input  logic        ex_is_load,
    output logic        BRANCH,
    output logic        STALL,
    output logic [15:0] branch_instr_addr,
    output logic        ex_valid,
    output logic [3:0]  ex_op,
    output logic [2:0]  ex_rd,
    output logic        ex_wr,
    output logic [15:0] ex_a,
    output logic [15:0] ex_b,
    output logic [15:0] ex_imm,
    output logic [15:0] ex_pc
`ifdef ID_PERF_CNT_EN
    ,
    output logic [15:0] stall_cnt,
    output logic [15:0] branch_cnt
`endif
);
    localparam int CW = $clog2(FETCH_SHADOW + 2);
    typedef enum logic [1:0] {SHADOW, RUN, HALTED} state_t;
    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [15:0]   r_rf [NREGS];
    logic [3:0]    w_op;
    logic [2:0]    w_rd, w_rs, w_rt;
    logic [15:0]   w_imm, w_rs_val, w_rt_val, w_rd_val;
    logic          w_rtype, w_alu, w_is_br, w_jmp, w_use_rs, w_use_rt, w_use_rd;
    logic          w_ex_hit, w_mem_hit, w_hz, w_run, w_taken, w_redirect, w_issue;
    assign w_op     = (id_instr[15:12] inside {[4'hB:4'hE]}) ? 4'h0 : id_instr[15:12];
    assign w_rd     = id_instr[11:9];
    assign w_rs     = id_instr[8:6];
    assign w_rt     = id_instr[5:3];
    assign w_imm    = {{10{id_instr[5]}}, id_instr[5:0]};
    assign w_rtype  = w_op >= 4'h1 && w_op <= 4'h4;
    assign w_alu    = w_op >= 4'h1 && w_op <= 4'h6;
    assign w_is_br  = w_op == 4'h8 || w_op == 4'h9;
    assign w_jmp    = w_op == 4'hA;
    assign w_use_rs = w_alu || w_op == 4'h7 || w_is_br;
    assign w_use_rt = w_rtype;
    assign w_use_rd = w_op == 4'h7 || w_is_br;
    // Writeback bypass lets an instruction see a value retiring in the same cycle.
    assign w_rs_val = (w_rs == 3'd0) ? 16'h0 : (wb_wr_en && wb_rd == w_rs) ? wb_data : r_rf[w_rs];
    assign w_rt_val = (w_rt == 3'd0) ? 16'h0 : (wb_wr_en && wb_rd == w_rt) ? wb_data : r_rf[w_rt];
    assign w_rd_val = (w_rd == 3'd0) ? 16'h0 : (wb_wr_en && wb_rd == w_rd) ? wb_data : r_rf[w_rd];
    assign w_ex_hit  = ex_dst_vld && ex_dst != 3'd0 &&
                       ((w_use_rs && ex_dst == w_rs) || (w_use_rt && ex_dst == w_rt) || (w_use_rd && ex_dst == w_rd));
    assign w_mem_hit = mem_dst_vld && mem_dst != 3'd0 &&
                       ((w_use_rs && mem_dst == w_rs) || (w_use_rt && mem_dst == w_rt) || (w_use_rd && mem_dst == w_rd));
    // Branches compare in ID, so any in-flight producer must drain first.
    assign w_hz       = (ex_is_load && w_ex_hit) || (w_is_br && (w_ex_hit || w_mem_hit));
    assign w_run      = r_state == RUN;
    assign w_taken    = (w_op == 4'h8 && w_rs_val == w_rd_val) || (w_op == 4'h9 && w_rs_val != w_rd_val);
    assign w_redirect = w_run && !w_hz && (w_taken || w_jmp);
    assign w_issue    = w_run && !w_hz && w_op != 4'hF;
    assign BRANCH            = w_redirect;
    assign STALL             = r_state == HALTED || (w_run && w_hz);
    assign branch_instr_addr = !w_redirect ? 16'h0 :
                               w_jmp ? {id_instr_addr[15:12], id_instr[11:0]} : id_instr_addr + 16'd1 + w_imm;
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (r_state == SHADOW) begin
            w_state_nxt = (r_cnt <= CW'(1)) ? RUN : SHADOW;
            w_cnt_nxt   = r_cnt - CW'(1);
        end else if (w_run) begin
            w_state_nxt = w_hz ? RUN : w_redirect ? SHADOW : (w_op == 4'hF) ? HALTED : RUN;
            w_cnt_nxt   = w_redirect ? CW'(FETCH_SHADOW) : r_cnt;
        end
    end
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state <= SHADOW;
            r_cnt   <= CW'(FETCH_SHADOW);
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) r_rf[i] <= 16'h0;
        end else if (wb_wr_en && wb_rd != 3'd0) begin
            r_rf[wb_rd] <= wb_data;
        end
    end
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            ex_valid <= 1'b0;
            ex_wr    <= 1'b0;
            ex_op    <= 4'h0;
            ex_rd    <= 3'd0;
            ex_a     <= 16'h0;
            ex_b     <= 16'h0;
            ex_imm   <= 16'h0;
            ex_pc    <= 16'(RESET_VECTOR);
        end else begin
            ex_valid <= w_issue;
            ex_wr    <= w_issue && w_alu && w_rd != 3'd0;
            ex_op    <= w_issue ? w_op : 4'h0;
            if (w_issue) begin
                ex_rd  <= w_rd;
                ex_a   <= w_rs_val;
                ex_b   <= w_use_rd ? w_rd_val : w_rt_val;
                ex_imm <= w_imm;
                ex_pc  <= id_instr_addr;
            end else if (r_state == SHADOW) begin
                ex_pc  <= 16'(RESET_VECTOR);
            end
        end
    end
`ifdef ID_PERF_CNT_EN
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            stall_cnt  <= 16'h0;
            branch_cnt <= 16'h0;
        end else begin
            if (w_run && w_hz && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
            if (w_redirect && branch_cnt != 16'hFFFF) branch_cnt <= branch_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage of the 16-bit 5-stage pipeline; the consumer of the fetch stage's id_instr/id_instr_addr.
- Decodes the instruction and reads the 8x16 register file.
- Resolves branches and jumps, detects hazards, and drives BRANCH/STALL/branch_instr_addr back to fetch.
- Launches a registered ID/EX bundle to the execute stage.

Parameters:
- RESET_VECTOR, 8: address fetch restarts from; reported on ex_pc while squashing.
- FETCH_SHADOW, 2: cycles of incoming id_instr discarded after reset or a taken branch (fetch pipeline depth).
- NREGS, 8: register count; r0 reads zero.

Ports:
- CLOCK_50  in  1  clock.
- reset  in  1  reset.
- id_instr  in  16  instruction from fetch.
- id_instr_addr  in  16  address of id_instr.
- wb_wr_en  in  1  writeback enable.
- wb_rd  in  3  writeback register.
- wb_data  in  16  writeback data.
- ex_dst_vld, mem_dst_vld  in  1 each  EX/MEM instruction writes a register.
- ex_dst, mem_dst  in  3 each  that register.
- ex_is_load  in  1  EX instruction is LW.
- BRANCH  out  1  redirect fetch (combinational).
- STALL  out  1  hold fetch (combinational).
- branch_instr_addr  out  16  redirect target (combinational).
- ex_valid  out  1  bundle valid.
- ex_op  out  4  opcode.
- ex_rd  out  3  destination register.
- ex_wr  out  1  bundle writes ex_rd.
- ex_a, ex_b, ex_imm, ex_pc  out  16 each  operand A, operand B, sign-extended immediate, instruction address.

Behaviour:
- Interface decision: one clock CLOCK_50; reset is asynchronous and active-high.
- Encoding: op[15:12], rd[11:9], rs[8:6], rt[5:3], imm6[5:0], imm12[11:0].
- Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 ADDI, 6 LW, 7 SW, 8 BEQ, 9 BNE, A JMP, F HALT. Others decode as NOP.
- Source registers:
  - R-type: rs, rt.
  - ADDI, LW: rs.
  - SW, BEQ, BNE: rs, rd.
  - JMP, NOP, HALT: none.
- Register file: NREGS x16. Written on posedge when wb_wr_en and wb_rd != 0. Same-cycle write-to-read bypass on wb_rd match. Cleared to 0 on reset.
- FSM states: SHADOW, RUN, HALTED. A down-counter cnt tracks shadow length.
- Reset (async):
  - state=SHADOW, cnt=FETCH_SHADOW.
  - ex_valid=0, ex_wr=0, ex_op=0, ex_rd=0, ex_a=ex_b=ex_imm=0, ex_pc=RESET_VECTOR.
- SHADOW:
  - id_instr ignored; BRANCH=0, STALL=0; bubble issued.
  - cnt decrements each cycle; moves to RUN when cnt reaches 1.
- RUN, hazard:
  - hz = (ex_is_load & ex_dst_vld & ex_dst!=0 & ex_dst matches any source).
  - For BEQ/BNE, hz additionally includes any ex/mem dst match (dst!=0).
  - hz -> STALL=1, BRANCH=0, bubble issued; instruction re-examined next cycle (fetch holds it).
- RUN, no hazard:
  - Taken branch (BEQ equal / BNE unequal), target = id_instr_addr+1+sext(imm6).
  - JMP, target = {id_instr_addr[15:12],imm12}.
  - Either case: BRANCH=1 for exactly this cycle, branch_instr_addr=target. The bundle issued is the branch itself with ex_wr=0. Then state=SHADOW, cnt=FETCH_SHADOW.
  - Not-taken branch: BRANCH=0.
- Targets wrap modulo 2^16.
- HALT: issued once as a bubble; then HALTED. HALTED holds STALL=1, BRANCH=0, bubbles only, until reset.
- Priority: reset > HALTED > SHADOW > hazard stall > branch.
- Bundle (registered, 1-cycle latency):
  - ex_a = R[rs].
  - ex_b = R[rt] for R-type; R[rd] for SW, BEQ, BNE.
  - ex_imm = sext(imm6).
  - ex_pc = id_instr_addr.
  - ex_wr=1 for ops 1–6 with rd!=0.
- Bubble: ex_valid=0, ex_wr=0, ex_op=0; other fields don't-care.
- branch_instr_addr = 0 whenever BRANCH=0.
- Reset mid-branch: outputs drop asynchronously to reset values, BRANCH=0 immediately.

Optional Feature:
- ID_PERF_CNT_EN defined: adds outputs stall_cnt[15:0] and branch_cnt[15:0].
  - Counters increment on each cycle STALL=1 in RUN (hazard only) and on each BRANCH=1, respectively.
  - Saturate at 16'hFFFF; reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset release with id_instr=ADD r1,r2,r3 held -> ex_valid=0 for 2 cycles, then ex_valid=1, ex_op=1, ex_rd=1, ex_wr=1.
- wb writes r2=16'h0005 in the same cycle id_instr=ADDI r1,r2,#-1 -> ex_a=16'h0005, ex_imm=16'hFFFF; r0 write with 16'h1234 -> r0 reads 0.
- ex_is_load=1, ex_dst=2 while id_instr=SUB r3,r2,r4 -> STALL=1 and bubble for 1 cycle; ex_is_load=0 next cycle -> SUB issues, STALL=0.
- BEQ r1,r1,#+3 at addr 16'h0010 -> BRANCH=1 for 1 cycle, branch_instr_addr=16'h0014, then 2 bubbles; BNE r1,r1 -> no BRANCH.
- JMP imm12=12'hABC at addr 16'h5000 -> branch_instr_addr=16'h5ABC; BEQ at addr 16'hFFFF with imm6=0 -> target 16'h0000 (wrap).
- HALT -> STALL stays 1 for 20 cycles, ex_valid=0 throughout; assert reset -> STALL=0 asynchronously, ex_pc=8.
